// File: rtl/conv_accum_buffer.sv
// Purpose : multi-lane partial-sum accumulator (read-modify-write over an SDP BRAM) with clear sweep and drain port.
// Latency : accumulate writes back one cycle after accept; drain read data one cycle after accept; clear takes DEPTH cycles.
// Backpressure: acc_ready_o drops during a clear or while a clear waits for the pipe; rd_ready_o drops during a clear or when an accumulate is presented.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   clear_start_i             pulse to begin zeroing sweep; clr_busy_o / clr_done_o report it
//   acc_valid_i/acc_ready_o   accumulate handshake; acc_addr_i row, acc_data_i LANES packed signed addends
//                             (lane 0 in LSBs), acc_mask_i per-lane enable, acc_first_i overwrite instead of add
//   rd_en_i/rd_ready_o        drain read handshake; rd_addr_i row, rd_data_o / rd_valid_o one cycle later
//   ovf_sticky_o              a lane saturated/wrapped since the last clear
module conv_accum_buffer #(
  parameter int M_TOTAL = 3136,
  parameter int N_TOTAL = 64,
  parameter int LANES   = 8,
  parameter int IN_W    = 24,
  parameter int ACC_W   = 32,
  parameter int SAT_EN  = 1,
  localparam int DEPTH  = M_TOTAL * N_TOTAL / LANES,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clear_start_i,
  output logic                   clr_busy_o,
  output logic                   clr_done_o,
  input  logic                   acc_valid_i,
  output logic                   acc_ready_o,
  input  logic [AW-1:0]          acc_addr_i,
  input  logic [LANES*IN_W-1:0]  acc_data_i,
  input  logic [LANES-1:0]       acc_mask_i,
  input  logic                   acc_first_i,
  input  logic                   rd_en_i,
  output logic                   rd_ready_o,
  input  logic [AW-1:0]          rd_addr_i,
  output logic [LANES*ACC_W-1:0] rd_data_o,
  output logic                   rd_valid_o,
  output logic                   ovf_sticky_o
);

  typedef logic [LANES-1:0][ACC_W-1:0] row_t;
  typedef logic [LANES-1:0][IN_W-1:0]  add_t;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam logic [AW-1:0]    LAST_ROW   = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    PENULT_ROW = AW'(DEPTH - 2);
  localparam logic [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

  // FSM / control state
  state_t        state_q;
  logic [AW-1:0] clr_cnt_q;
  logic          clr_busy_q, clr_done_q, clr_pend_q, ovf_q;

  // S2 stage
  logic          s2_vld_q;
  logic [AW-1:0] s2_addr_q;
  add_t          s2_dat_q;
  logic [LANES-1:0] s2_mask_q;
  logic          s2_first_q;
  row_t          s2_new;
  logic [LANES-1:0] lane_ovf;

  // memory and read-side registers
  row_t          mem_q [DEPTH];
  row_t          mem_rd_q;
  logic          fwd_q;
  row_t          fwd_dat_q;
  row_t          cur_row;
  logic          rd_vld_q;
  row_t          rd_hold_q;

  logic          acc_go, rd_go, clr_go, mem_we;
  logic [AW-1:0] rd_ptr, mem_wa;
  row_t          mem_wd;
  add_t          acc_dat;

  assign acc_dat     = acc_data_i;
  assign acc_ready_o = !clr_busy_q && !clr_pend_q;
  assign rd_ready_o  = !clr_busy_q && !acc_valid_i;
  assign acc_go      = acc_valid_i && acc_ready_o;
  assign rd_go       = rd_en_i && rd_ready_o;
  // A clear only launches with nothing in S2 and nothing entering S1, so no
  // accumulate write can land on top of (or after) the sweep.
  assign clr_go      = (state_q == ST_IDLE) && (clear_start_i || clr_pend_q) && !s2_vld_q && !acc_go;

  // The single read port serves either the accumulate or the drain read.
  assign rd_ptr = acc_go ? acc_addr_i : rd_addr_i;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = s2_addr_q;
    mem_wd = s2_new;
    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt_q;
      mem_wd = '0;
    end else if (s2_vld_q) begin
      mem_we = 1'b1;
    end
  end

  // Read-first BRAM: a same-cycle write is not visible, hence the forward path.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
    if (acc_go || rd_go) mem_rd_q <= mem_q[rd_ptr];
  end

  // S2's result (masked lanes already hold their old value) replaces stale memory data.
  assign cur_row = fwd_q ? fwd_dat_q : mem_rd_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [ACC_W-1:0] old_v, sext_v, new_v;
    logic [ACC_W:0]   sum_v;
    logic             ovf_v;

    assign old_v  = cur_row[g];
    assign sext_v = ACC_W'($signed(s2_dat_q[g]));
    assign sum_v  = {old_v[ACC_W-1], old_v} + {sext_v[ACC_W-1], sext_v};
    assign ovf_v  = sum_v[ACC_W] ^ sum_v[ACC_W-1];
    assign new_v  = !s2_mask_q[g]            ? old_v :
                    s2_first_q               ? sext_v :
                    (ovf_v && SAT_EN != 0)   ? (sum_v[ACC_W] ? ACC_MIN : ACC_MAX) :
                                               sum_v[ACC_W-1:0];
    assign s2_new[g]   = new_v;
    assign lane_ovf[g] = s2_mask_q[g] && !s2_first_q && ovf_v;
  end

  // Clear FSM with registered busy/done; done overlaps the final row write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      clr_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_go) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b1;
            clr_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
          end else begin
            if (clear_start_i) clr_pend_q <= 1'b1;
            if (s2_vld_q && (|lane_ovf)) ovf_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q  <= clr_cnt_q + 1'b1;
          clr_done_q <= (clr_cnt_q == PENULT_ROW);
          if (clr_cnt_q == LAST_ROW) begin
            state_q    <= ST_IDLE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_vld_q  <= 1'b0;
      fwd_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      s2_vld_q <= acc_go;
      rd_vld_q <= rd_go;
      if (acc_go || rd_go) fwd_q <= s2_vld_q && (s2_addr_q == rd_ptr);
      if (rd_vld_q) rd_hold_q <= cur_row;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc_go) begin
      s2_addr_q  <= acc_addr_i;
      s2_dat_q   <= acc_dat;
      s2_mask_q  <= acc_mask_i;
      s2_first_q <= acc_first_i;
    end
    if (acc_go || rd_go) fwd_dat_q <= s2_new;
  end

  // rd_data holds the last returned row between reads.
  assign rd_data_o    = rd_vld_q ? cur_row : rd_hold_q;
  assign rd_valid_o   = rd_vld_q;
  assign clr_busy_o   = clr_busy_q;
  assign clr_done_o   = clr_done_q;
  assign ovf_sticky_o = ovf_q;

endmodule

// File: tb/tb_conv_accum_buffer.sv
module tb_conv_accum_buffer;

  localparam int DEPTH = 25088;   // 3136*64/8
  localparam int AW    = 15;
  localparam int AW_W  = 6;       // wrap instance: 8*64/8 = 64 rows

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear_start, acc_valid, acc_first, rd_en;
  logic [AW-1:0] acc_addr, rd_addr;
  logic [191:0]  acc_data;
  logic [7:0]    acc_mask;

  logic          busy, done, acc_ready, rd_ready, rd_valid, ovf;
  logic [255:0]  rd_data;
  logic          w_busy, w_done, w_acc_ready, w_rd_ready, w_rd_valid, w_ovf;
  logic [255:0]  w_rd_data;

  int n_chk = 0;
  int n_bad = 0;

  conv_accum_buffer u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_start_i(clear_start),
    .clr_busy_o(busy), .clr_done_o(done),
    .acc_valid_i(acc_valid), .acc_ready_o(acc_ready), .acc_addr_i(acc_addr),
    .acc_data_i(acc_data), .acc_mask_i(acc_mask), .acc_first_i(acc_first),
    .rd_en_i(rd_en), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .ovf_sticky_o(ovf)
  );

  // Small wrap-mode instance sharing the same stimulus (all test rows < 64).
  conv_accum_buffer #(.M_TOTAL(8), .SAT_EN(0)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .clear_start_i(clear_start),
    .clr_busy_o(w_busy), .clr_done_o(w_done),
    .acc_valid_i(acc_valid), .acc_ready_o(w_acc_ready), .acc_addr_i(acc_addr[AW_W-1:0]),
    .acc_data_i(acc_data), .acc_mask_i(acc_mask), .acc_first_i(acc_first),
    .rd_en_i(rd_en), .rd_ready_o(w_rd_ready), .rd_addr_i(rd_addr[AW_W-1:0]),
    .rd_data_o(w_rd_data), .rd_valid_o(w_rd_valid), .ovf_sticky_o(w_ovf)
  );

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic acc_cyc(input logic [AW-1:0] a, input logic [23:0] d,
                         input logic [7:0] m, input logic f);
    acc_valid = 1'b1; acc_addr = a; acc_data = {8{d}}; acc_mask = m; acc_first = f;
    @(negedge clk);
  endtask

  task automatic acc_stop();
    acc_valid = 1'b0; acc_first = 1'b0;
  endtask

  task automatic read_row(input logic [AW-1:0] a, output logic v,
                          output logic [255:0] r, output logic [255:0] rw);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    v = rd_valid; r = rd_data; rw = w_rd_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; clear_start = 1'b0; acc_valid = 1'b0; acc_first = 1'b0; rd_en = 1'b0;
    acc_addr = '0; rd_addr = '0; acc_data = '0; acc_mask = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_chk++; if (rd_data !== 256'd0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_chk++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (acc_ready !== 1'b1) begin n_bad++; $display("FAIL idle_acc_ready: got %b want 1", acc_ready); end
    n_chk++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_rd_ready: got %b want 1", rd_ready); end
  endtask

  // Clear requested in the same cycle as an accepted accumulate: it must wait for S2.
  task automatic test_clear();
    int busy_n, done_n, w_done_n, done_idx, last_busy, nz, inval;
    busy_n = 0; done_n = 0; w_done_n = 0; done_idx = -1; last_busy = -2; nz = 0; inval = 0;
    clear_start = 1'b1;
    acc_cyc(0, 24'h000042, 8'hFF, 1'b1);
    clear_start = 1'b0;
    acc_stop();
    #1;
    n_chk++; if (acc_ready !== 1'b0) begin n_bad++; $display("FAIL pend_acc_ready: got %b want 0", acc_ready); end
    n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pend_busy_early: got %b want 0", busy); end
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pend_busy_drain: got %b want 0", busy); end
    for (int i = 0; i < DEPTH + 10; i++) begin
      @(negedge clk);
      if (busy) begin busy_n++; last_busy = i; end
      if (done) begin done_n++; done_idx = i; end
      if (w_done) w_done_n++;
    end
    n_chk++; if (busy_n !== DEPTH) begin n_bad++; $display("FAIL clr_busy_cycles: got %0d want %0d", busy_n, DEPTH); end
    n_chk++; if (done_n !== 1) begin n_bad++; $display("FAIL clr_done_pulses: got %0d want 1", done_n); end
    n_chk++; if (done_idx !== last_busy) begin n_bad++; $display("FAIL clr_done_timing: got cycle %0d want %0d", done_idx, last_busy); end
    n_chk++; if (w_done_n !== 1) begin n_bad++; $display("FAIL wrap_clr_done_pulses: got %0d want 1", w_done_n); end
    n_chk++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL clr_ovf: got %b want 0", ovf); end
    // stream one read per cycle across every row
    rd_en = 1'b1; rd_addr = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      if (rd_valid !== 1'b1) inval++;
      if (rd_data !== 256'd0) nz++;
      if (i < DEPTH) rd_addr = AW'(i); else rd_en = 1'b0;
    end
    n_chk++; if (nz !== 0) begin n_bad++; $display("FAIL clr_rows_nonzero: got %0d want 0", nz); end
    n_chk++; if (inval !== 0) begin n_bad++; $display("FAIL clr_read_invalid: got %0d want 0", inval); end
  endtask

  task automatic test_forward();
    logic v; logic [255:0] r, rw, e; logic [31:0] l;
    acc_cyc(5, 24'd1, 8'hFF, 1'b1);
    acc_cyc(5, 24'd2, 8'hFF, 1'b0);
    acc_cyc(5, 24'd3, 8'hFF, 1'b0);
    acc_cyc(5, 24'd4, 8'hFF, 1'b0);
    acc_stop();
    read_row(5, v, r, rw);
    l = 32'd10; e = {8{l}};
    n_chk++; if (v !== 1'b1) begin n_bad++; $display("FAIL fwd_valid: got %b want 1", v); end
    n_chk++; if (r !== e) begin n_bad++; $display("FAIL fwd_row5: got %h want %h", r, e); end
    n_chk++; if (rw !== e) begin n_bad++; $display("FAIL fwd_row5_wrap: got %h want %h", rw, e); end
  endtask

  task automatic test_alternate();
    logic v; logic [255:0] r, rw, e; logic [31:0] l;
    for (int i = 0; i < 6; i++) acc_cyc((i % 2 == 0) ? 15'd3 : 15'd7, 24'd1, 8'hFF, 1'b0);
    acc_stop();
    l = 32'd3; e = {8{l}};
    read_row(3, v, r, rw);
    n_chk++; if (r !== e) begin n_bad++; $display("FAIL alt_row3: got %h want %h", r, e); end
    read_row(7, v, r, rw);
    n_chk++; if (r !== e) begin n_bad++; $display("FAIL alt_row7: got %h want %h", r, e); end
  endtask

  task automatic test_mask();
    logic v; logic [255:0] r, rw, e; logic [31:0] l2, l9;
    acc_cyc(9, 24'd2, 8'hFF, 1'b1);
    acc_cyc(9, 24'd7, 8'b0000_0001, 1'b0);
    acc_stop();
    read_row(9, v, r, rw);
    l2 = 32'd2; l9 = 32'd9; e = {{7{l2}}, l9};
    n_chk++; if (r !== e) begin n_bad++; $display("FAIL mask_row9: got %h want %h", r, e); end
  endtask

  task automatic test_rd_forward();
    logic v; logic [255:0] r, rw, e; logic [31:0] l;
    acc_cyc(40, 24'd123, 8'hFF, 1'b1);
    acc_stop();
    read_row(40, v, r, rw);   // accepted on the edge where S2 writes row 40
    l = 32'd123; e = {8{l}};
    n_chk++; if (v !== 1'b1) begin n_bad++; $display("FAIL rdfwd_valid: got %b want 1", v); end
    n_chk++; if (r !== e) begin n_bad++; $display("FAIL rdfwd_data: got %h want %h", r, e); end
    @(negedge clk);
    n_chk++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid); end
    n_chk++; if (rd_data !== e) begin n_bad++; $display("FAIL rd_data_hold: got %h want %h", rd_data, e); end
  endtask

  task automatic test_rd_blocked();
    logic [255:0] e; logic [31:0] l;
    rd_en = 1'b1; rd_addr = 30;
    acc_valid = 1'b1; acc_addr = 30; acc_data = {8{24'd5}}; acc_mask = 8'hFF; acc_first = 1'b1;
    #1;
    n_chk++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL blk_rd_ready0: got %b want 0", rd_ready); end
    @(negedge clk);
    n_chk++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL blk_rd_valid0: got %b want 0", rd_valid); end
    acc_data = {8{24'd6}}; acc_first = 1'b0;
    @(negedge clk);
    acc_stop();
    #1;
    n_chk++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL blk_rd_ready1: got %b want 1", rd_ready); end
    @(negedge clk);
    rd_en = 1'b0;
    l = 32'd11; e = {8{l}};
    n_chk++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL blk_rd_valid1: got %b want 1", rd_valid); end
    n_chk++; if (rd_data !== e) begin n_bad++; $display("FAIL blk_rd_data: got %h want %h", rd_data, e); end
  endtask

  // 256 * 0x7FFFFF + 246 = 2^31-10; then +100 overflows.
  task automatic test_saturate();
    logic v; logic [255:0] r, rw, es, ew; logic [31:0] ls, lw;
    acc_cyc(20, 24'h7FFFFF, 8'hFF, 1'b1);
    for (int i = 0; i < 255; i++) acc_cyc(20, 24'h7FFFFF, 8'hFF, 1'b0);
    acc_cyc(20, 24'd246, 8'hFF, 1'b0);
    acc_stop();
    repeat (2) @(negedge clk);
    n_chk++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL sat_ovf_pre: got %b want 0", ovf); end
    n_chk++; if (w_ovf !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf_pre: got %b want 0", w_ovf); end
    acc_cyc(20, 24'd100, 8'hFF, 1'b0);
    acc_stop();
    read_row(20, v, r, rw);
    ls = 32'h7FFF_FFFF;     // clamp to 2^31-1
    lw = 32'h8000_005A;     // 2^31+90 wrapped = -2^31+90
    es = {8{ls}}; ew = {8{lw}};
    n_chk++; if (r !== es) begin n_bad++; $display("FAIL sat_value: got %h want %h", r, es); end
    n_chk++; if (rw !== ew) begin n_bad++; $display("FAIL wrap_value: got %h want %h", rw, ew); end
    n_chk++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf: got %b want 1", ovf); end
    n_chk++; if (w_ovf !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf: got %b want 1", w_ovf); end
  endtask

  task automatic test_reset_mid_sweep();
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (40) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sweep_busy: got %b want 1", busy); end
    n_chk++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL sweep_ovf_cleared: got %b want 0", ovf); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    n_chk++; if (rd_data !== 256'd0) begin n_bad++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    n_chk++; if (w_busy !== 1'b0) begin n_bad++; $display("FAIL rst_wrap_busy: got %b want 0", w_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_forward();
    test_alternate();
    test_mask();
    test_rd_forward();
    test_rd_blocked();
    test_saturate();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
